// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state codes and constants for the next-PC sequencer
package pc_sequencer_pkg;

    // State codes are also shown by the ID and hazard units' debug ports.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } seq_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;

    typedef struct packed {
        logic        valid;
        logic [31:0] target;
        logic        misalign;
    } redirect_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - pending-redirect register with jump-over-branch select
module pc_redirect_buf
    import pc_sequencer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        capture_i,
    input  logic        clear_i,
    output redirect_t   req_o,
    output logic        pend_valid_o,
    output logic [31:0] pend_target_o
);

    logic        pend_valid;
    logic [31:0] pend_target;

    always_comb begin
        req_o = '0;
        if (jump_i) begin
            req_o.valid    = 1'b1;
            req_o.target   = word_align(jump_target_i);
            req_o.misalign = |jump_target_i[1:0];
        end else if (branch_i) begin
            req_o.valid    = 1'b1;
            req_o.target   = word_align(branch_target_i);
            req_o.misalign = |branch_target_i[1:0];
        end
    end

    // A newer redirect replaces whatever is already parked.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else if (capture_i && req_o.valid) begin
            pend_valid  <= 1'b1;
            pend_target <= req_o.target;
        end else if (clear_i) begin
            pend_valid  <= 1'b0;
        end
    end

    assign pend_valid_o  = pend_valid;
    assign pend_target_o = pend_target;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC controller: boot, sequential fetch, redirects, stalls
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        pc_we_o,
    output logic        flush_o,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o,
    output logic [1:0]  state_o
);

    seq_state_e  state;
    logic        misalign_q;
    logic [31:0] fetch_cnt_q;

    redirect_t   req;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        capture;
    logic        clear_pend;
    logic        take_direct;

    pc_redirect_buf u_redirect_buf (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .capture_i       (capture),
        .clear_i         (clear_pend),
        .req_o           (req),
        .pend_valid_o    (pend_valid),
        .pend_target_o   (pend_target)
    );

    // Next-PC selection is combinational so the PC register loads on this edge.
    always_comb begin
        pc_next_o   = pc_i;
        pc_we_o     = 1'b0;
        flush_o     = 1'b0;
        capture     = 1'b0;
        clear_pend  = 1'b0;
        take_direct = 1'b0;
        case (state)
            ST_BOOT: begin
                pc_next_o = RESET_PC;
                pc_we_o   = 1'b1;
                flush_o   = 1'b1;
            end
            ST_RUN: begin
                if (!start_i || stall_i) begin
                    capture = 1'b1;
                end else if (pend_valid) begin
                    pc_next_o  = pend_target;
                    pc_we_o    = 1'b1;
                    flush_o    = 1'b1;
                    clear_pend = 1'b1;
                end else if (req.valid) begin
                    pc_next_o   = req.target;
                    pc_we_o     = 1'b1;
                    flush_o     = 1'b1;
                    take_direct = 1'b1;
                end else begin
                    pc_next_o = pc_i + PC_INC;
                    pc_we_o   = 1'b1;
                end
            end
            ST_HOLD: capture = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            misalign_q  <= 1'b0;
            fetch_cnt_q <= 32'h0;
        end else begin
            if (pc_we_o) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((capture || take_direct) && req.misalign) begin
                misalign_q <= 1'b1;
            end
            case (state)
                ST_IDLE: if (start_i) state <= ST_BOOT;
                ST_BOOT: state <= ST_RUN;
                ST_RUN:  if (!start_i) state <= ST_HOLD;
                ST_HOLD: if (start_i) state <= ST_RUN;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign misalign_o  = misalign_q;
    assign fetch_cnt_o = fetch_cnt_q;
    assign state_o     = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, start, stall, jump, branch;
    logic [31:0] jump_target, branch_target, pc;
    logic [31:0] pc_next, fetch_cnt;
    logic        pc_we, flush, misalign;
    logic [1:0]  state;

    pc_sequencer #(.RESET_PC(RST_PC), .PC_INC(32'd4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .stall_i         (stall),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .branch_i        (branch),
        .branch_target_i (branch_target),
        .pc_i            (pc),
        .pc_next_o       (pc_next),
        .pc_we_o         (pc_we),
        .flush_o         (flush),
        .misalign_o      (misalign),
        .fetch_cnt_o     (fetch_cnt),
        .state_o         (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit model_on = 0;

    // Reference model: mode 0=IDLE 1=BOOT 2=RUN 3=HOLD, parked redirect, sticky flag, counter.
    int          m_mode;
    bit          m_pv;
    logic [31:0] m_pt;
    bit          m_mis;
    logic [31:0] m_cnt;

    logic [31:0] s_next, s_cnt;
    logic        s_we, s_flush, s_mis;
    logic [1:0]  s_state;

    typedef struct {
        bit          st, stl, j;
        logic [31:0] jt;
        bit          b;
        logic [31:0] bt, pcv;
        logic [1:0]  e_state;
        bit          e_we, e_flush, chk_next;
        logic [31:0] e_next, e_cnt;
        bit          e_mis;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit st, input bit stl, input bit j, input logic [31:0] jt,
                        input bit b, input logic [31:0] bt, input logic [31:0] pcv, input bit rs);
        logic [31:0] e_next, rt;
        bit e_we, e_flush, e_chk, cap, take, used_pend, rv;
        @(negedge clk);
        rst = rs; start = st; stall = stl; jump = j; jump_target = jt;
        branch = b; branch_target = bt; pc = pcv;
        #1;
        s_next = pc_next; s_we = pc_we; s_flush = flush;
        s_mis = misalign; s_cnt = fetch_cnt; s_state = state;

        rv = j || b;
        rt = j ? jt : bt;
        e_we = 0; e_flush = 0; e_next = pcv; e_chk = 0;
        cap = 0; take = 0; used_pend = 0;
        case (m_mode)
            0: e_chk = 1;
            1: begin e_we = 1; e_flush = 1; e_next = RST_PC; e_chk = 1; end
            2: begin
                if (!st || stl) cap = 1;
                else if (m_pv) begin
                    e_next = m_pt; e_we = 1; e_flush = 1; e_chk = 1; used_pend = 1;
                end else if (rv) begin
                    e_next = rt & ~32'd3; e_we = 1; e_flush = 1; e_chk = 1; take = 1;
                end else begin
                    e_next = pcv + 32'd4; e_we = 1; e_chk = 1;
                end
            end
            default: cap = 1;
        endcase

        if (model_on) begin
            chk("state", {30'd0, s_state}, m_mode);
            chk("pc_we", {31'd0, s_we}, {31'd0, e_we});
            chk("flush", {31'd0, s_flush}, {31'd0, e_flush});
            chk("misalign", {31'd0, s_mis}, {31'd0, m_mis});
            chk("fetch_cnt", s_cnt, m_cnt);
            if (e_chk) chk("pc_next", s_next, e_next);
        end

        if (!rs) begin
            m_mode = 0; m_pv = 0; m_pt = 0; m_mis = 0; m_cnt = 0;
        end else begin
            if (e_we) m_cnt = m_cnt + 32'd1;
            if ((cap || take) && rv && (rt[1:0] != 2'b00)) m_mis = 1;
            if (cap && rv) begin m_pv = 1; m_pt = rt & ~32'd3; end
            else if (used_pend) m_pv = 0;
            case (m_mode)
                0: if (st) m_mode = 1;
                1: m_mode = 2;
                2: if (!st) m_mode = 3;
                default: if (st) m_mode = 2;
            endcase
        end
        @(posedge clk);
    endtask

    task automatic add(input bit st, input bit stl, input bit j, input logic [31:0] jt,
                       input bit b, input logic [31:0] bt, input logic [31:0] pcv,
                       input logic [1:0] es, input bit ew, input bit ef, input bit cn,
                       input logic [31:0] en, input logic [31:0] ec, input bit em);
        vec_t v;
        v.st = st; v.stl = stl; v.j = j; v.jt = jt; v.b = b; v.bt = bt; v.pcv = pcv;
        v.e_state = es; v.e_we = ew; v.e_flush = ef; v.chk_next = cn;
        v.e_next = en; v.e_cnt = ec; v.e_mis = em;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] p;
        rst = 0; start = 0; stall = 0; jump = 0; branch = 0;
        jump_target = 0; branch_target = 0; pc = 0;
        m_mode = 0; m_pv = 0; m_pt = 0; m_mis = 0; m_cnt = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        model_on = 1;

        //  st stl j jt            b bt           pc             st we fl cn next          cnt mis
        add(0, 0, 0, 0,            0, 0,          32'h55,        0, 0, 0, 1, 32'h55,       0,  0);
        add(1, 0, 0, 0,            0, 0,          32'h55,        0, 0, 0, 1, 32'h55,       0,  0);
        add(1, 1, 1, 32'h300,      0, 0,          32'h55,        1, 1, 1, 1, 32'h0,        0,  0);
        add(1, 0, 0, 0,            0, 0,          32'h0,         2, 1, 0, 1, 32'h4,        1,  0);
        add(1, 0, 0, 0,            0, 0,          32'h4,         2, 1, 0, 1, 32'h8,        2,  0);
        add(1, 0, 0, 0,            0, 0,          32'h8,         2, 1, 0, 1, 32'hC,        3,  0);
        add(1, 0, 0, 0,            1, 32'h40,     32'h10,        2, 1, 1, 1, 32'h40,       4,  0);
        add(1, 0, 0, 0,            0, 0,          32'h40,        2, 1, 0, 1, 32'h44,       5,  0);
        add(1, 1, 1, 32'h100,      1, 32'h200,    32'h44,        2, 0, 0, 0, 32'h0,        6,  0);
        add(1, 1, 0, 0,            0, 0,          32'h44,        2, 0, 0, 0, 32'h0,        6,  0);
        add(1, 0, 0, 0,            0, 0,          32'h44,        2, 1, 1, 1, 32'h100,      6,  0);
        add(1, 0, 0, 0,            0, 0,          32'h100,       2, 1, 0, 1, 32'h104,      7,  0);
        add(1, 0, 0, 0,            0, 0,          32'hFFFF_FFFC, 2, 1, 0, 1, 32'h0,        8,  0);
        add(1, 0, 1, 32'h103,      0, 0,          32'h0,         2, 1, 1, 1, 32'h100,      9,  0);
        add(1, 0, 0, 0,            0, 0,          32'h100,       2, 1, 0, 1, 32'h104,      10, 1);

        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].stl, vecs[i].j, vecs[i].jt, vecs[i].b, vecs[i].bt, vecs[i].pcv, 1);
            chk($sformatf("vec%0d.state", i), {30'd0, s_state}, {30'd0, vecs[i].e_state});
            chk($sformatf("vec%0d.we", i), {31'd0, s_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("vec%0d.flush", i), {31'd0, s_flush}, {31'd0, vecs[i].e_flush});
            chk($sformatf("vec%0d.cnt", i), s_cnt, vecs[i].e_cnt);
            chk($sformatf("vec%0d.mis", i), {31'd0, s_mis}, {31'd0, vecs[i].e_mis});
            if (vecs[i].chk_next) chk($sformatf("vec%0d.next", i), s_next, vecs[i].e_next);
        end

        p = 32'h104;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 0, 0, p, 1);
            chk("mis_sticky", {31'd0, s_mis}, 32'd1);
            p = p + 32'd4;
        end

        // Latest parked redirect wins.
        step(1, 1, 1, 32'h600, 0, 0, 32'h20, 1);
        step(1, 1, 0, 0, 1, 32'h704, 32'h20, 1);
        step(1, 0, 0, 0, 0, 0, 32'h20, 1);
        chk("overwrite.next", s_next, 32'h704);
        chk("overwrite.flush", {31'd0, s_flush}, 32'd1);

        // Redirect parked while held is applied on return to RUN.
        step(0, 0, 0, 0, 0, 0, 32'h704, 1);
        chk("hold.we", {31'd0, s_we}, 32'd0);
        step(0, 0, 1, 32'h800, 0, 0, 32'h704, 1);
        chk("hold.state", {30'd0, s_state}, 32'd3);
        step(1, 0, 0, 0, 0, 0, 32'h704, 1);
        chk("hold.we2", {31'd0, s_we}, 32'd0);
        step(1, 0, 0, 0, 0, 0, 32'h704, 1);
        chk("hold.next", s_next, 32'h800);
        chk("hold.flush", {31'd0, s_flush}, 32'd1);

        // Reset drops a parked redirect and clears misalign.
        step(1, 1, 1, 32'h500, 0, 0, 32'h800, 1);
        step(1, 1, 0, 0, 0, 0, 32'h800, 0);
        step(0, 0, 0, 0, 0, 0, 32'h800, 1);
        chk("rst.state", {30'd0, s_state}, 32'd0);
        chk("rst.mis", {31'd0, s_mis}, 32'd0);
        chk("rst.cnt", s_cnt, 32'd0);
        step(1, 0, 0, 0, 0, 0, 32'h800, 1);
        step(1, 0, 0, 0, 0, 0, 32'h800, 1);
        chk("rst.boot_next", s_next, RST_PC);
        chk("rst.boot_flush", {31'd0, s_flush}, 32'd1);
        step(1, 0, 0, 0, 0, 0, 32'h0, 1);
        chk("rst.first_seq", s_next, 32'h4);
        chk("rst.first_flush", {31'd0, s_flush}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 5) == 0, $urandom,
                 rp, $urandom_range(0, 199) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
